inst_mem_loader: RTL and testbench

Byte-stream image loader that writes 25-bit instructions into Instruction_Memory, the writer side of the instruction fetch path. It accepts a framed byte stream over a valid/ready handshake, assembles each four-byte group into one instruction, and issues single-cycle write strobes at sequential addresses. While a load is in progress it holds the processor in reset through CpuHold, and it reports Done or Error when the frame ends.

---
 rtl/loader_pkg.sv | 20 ++
 rtl/loader_checksum.sv | 34 +++
 rtl/inst_mem_loader.sv | 165 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the instruction-memory image loader:
// the state encoding, the frame header byte and the datapath widths.
package loader_pkg;

  localparam int INST_W = 25;
  localparam int ADDR_W = 8;

  localparam logic [7:0]        HEADER        = 8'hA5;
  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 8'h00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_e;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit running-sum accumulator with synchronous clear and add-enable.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_checksum (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr_i,
  input  logic       add_i,
  input  logic [7:0] byte_i,
  output logic [7:0] sum_o
);

  logic [7:0] sum_q;
  logic [7:0] sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr_i) begin
      sum_d = 8'h00;
    end else if (add_i) begin
      sum_d = sum_q + byte_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= 8'h00;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/inst_mem_loader.sv
// Framed byte-stream loader writing 25-bit instructions into instruction memory.
// Optional trailing checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter logic [7:0]        HEADER_BYTE = HEADER,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = BASE_ADDR_DEF
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  input  logic              Clear,
  output logic              InstWrite,
  output logic [ADDR_W-1:0] InstAddress,
  output logic [INST_W-1:0] InstData,
  output logic              CpuHold,
  output logic              Done,
  output logic              Error
);

  state_e              state_q;
  logic [1:0]          idx_q;
  logic [8:0]          cnt_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [23:0]         asm_q;
  logic                rdy_q;
  logic                inst_write_q;
  logic [ADDR_W-1:0]   inst_addr_q;
  logic [INST_W-1:0]   inst_data_q;
  logic                hold_q;
  logic                done_q;
  logic                error_q;

  logic xfer;

  // Clear always takes priority over a byte offered in the same cycle.
  assign ByteReady = rdy_q & ~Clear;
  assign xfer      = ByteValid & ByteReady;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_sum;
  logic [7:0] csum_total;
  logic       csum_clr;
  logic       csum_add;

  assign csum_clr   = (state_q == S_IDLE) && xfer && (ByteIn == HEADER_BYTE);
  assign csum_add   = xfer && ((state_q == S_COUNT) || (state_q == S_DATA));
  assign csum_total = csum_sum + ByteIn;

  loader_checksum u_checksum (
    .clk    (clk),
    .rst    (Reset),
    .clr_i  (csum_clr),
    .add_i  (csum_add),
    .byte_i (ByteIn),
    .sum_o  (csum_sum)
  );
`endif

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 9'd0;
      addr_q       <= '0;
      asm_q        <= 24'd0;
      rdy_q        <= 1'b1;
      inst_write_q <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
      hold_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      inst_write_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (xfer && (ByteIn == HEADER_BYTE)) begin
            state_q <= S_COUNT;
            hold_q  <= 1'b1;
          end
        end
        S_COUNT: begin
          if (xfer) begin
            cnt_q   <= (ByteIn == 8'd0) ? 9'd256 : {1'b0, ByteIn};
            addr_q  <= BASE_ADDR;
            idx_q   <= 2'd0;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (xfer) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
              2'd0: asm_q[7:0]   <= ByteIn;
              2'd1: asm_q[15:8]  <= ByteIn;
              2'd2: asm_q[23:16] <= ByteIn;
              default: begin
                if (ByteIn[7:1] != 7'd0) begin
                  state_q <= S_ERROR;
                  error_q <= 1'b1;
                  rdy_q   <= 1'b0;
                end else begin
                  inst_write_q <= 1'b1;
                  inst_addr_q  <= addr_q;
                  inst_data_q  <= {ByteIn[0], asm_q};
                  addr_q       <= addr_q + 8'd1;
                  cnt_q        <= cnt_q - 9'd1;
                  if (cnt_q == 9'd1) begin
`ifdef LOADER_CHECKSUM_EN
                    state_q <= S_CHECK;
`else
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                    hold_q  <= 1'b0;
                    rdy_q   <= 1'b0;
`endif
                  end
                end
              end
            endcase
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (xfer) begin
            rdy_q <= 1'b0;
            if (csum_total == 8'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              error_q <= 1'b1;
            end
          end
        end
`endif
        S_DONE, S_ERROR: begin
          // CpuHold is deliberately left alone; only a new header raises it.
          if (Clear) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign InstWrite   = inst_write_q;
  assign InstAddress = inst_addr_q;
  assign InstData    = inst_data_q;
  assign CpuHold     = hold_q;
  assign Done        = done_q;
  assign Error       = error_q;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Randomized scoreboard bench for inst_mem_loader; honours LOADER_CHECKSUM_EN.
module tb_inst_mem_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif
  localparam logic [7:0] TB_BASE = 8'hFE;
  localparam logic [7:0] HDR     = 8'hA5;
  localparam int R_DONE = 1;
  localparam int R_ERR  = 2;

  logic        clk = 1'b0;
  logic        Reset;
  logic [7:0]  ByteIn;
  logic        ByteValid;
  logic        ByteReady;
  logic        Clear;
  logic        InstWrite;
  logic [7:0]  InstAddress;
  logic [24:0] InstData;
  logic        CpuHold;
  logic        Done;
  logic        Error;

  inst_mem_loader #(.BASE_ADDR(TB_BASE)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .ByteIn      (ByteIn),
    .ByteValid   (ByteValid),
    .ByteReady   (ByteReady),
    .Clear       (Clear),
    .InstWrite   (InstWrite),
    .InstAddress (InstAddress),
    .InstData    (InstData),
    .CpuHold     (CpuHold),
    .Done        (Done),
    .Error       (Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [24:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] frame[$];
  int         passed = 0;
  int         total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Monitor: every write strobe must match the next expected write.
  always @(negedge clk) begin
    if (!Reset && InstWrite) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected none", InstAddress, InstData);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("write_addr", {24'd0, InstAddress}, {24'd0, w.addr});
        chk("write_data", {7'd0, InstData}, {7'd0, w.data});
      end
    end
  end

  // Reference model: interpret the frame by the protocol rules, queue the
  // writes it implies, and report how many bytes the loader will accept.
  task automatic model(output int consumed, output int result);
    int i, n;
    logic [7:0] sum, addr, b0, b1, b2, b3;
    i = 0;
    while (frame[i] != HDR) i++;
    i++;
    n = (frame[i] == 8'd0) ? 256 : int'(frame[i]);
    sum = frame[i];
    i++;
    addr = TB_BASE;
    for (int k = 0; k < n; k++) begin
      b0 = frame[i]; b1 = frame[i+1]; b2 = frame[i+2]; b3 = frame[i+3];
      i += 4;
      sum = sum + b0 + b1 + b2 + b3;
      if ((b3 >> 1) != 0) begin
        consumed = i;
        result   = R_ERR;
        return;
      end
      exp_q.push_back('{addr: addr, data: {b3[0], b2, b1, b0}});
      addr = addr + 8'd1;
    end
    result = R_DONE;
    if (CSUM) begin
      sum = sum + frame[i];
      i++;
      if (sum != 8'd0) result = R_ERR;
    end
    consumed = i;
  endtask

  task automatic add_csum();
    logic [7:0] s;
    int p;
    s = 8'd0;
    p = 0;
    while (frame[p] != HDR) p++;
    for (int j = p + 1; j < frame.size(); j++) s = s + frame[j];
    frame.push_back(8'd0 - s);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    ByteIn    = b;
    ByteValid = 1'b1;
    chk("byte_ready", {31'd0, ByteReady}, 32'd1);
    @(posedge clk);
    #1;
    ByteValid = 1'b0;
  endtask

  task automatic run_frame(input string nm);
    int consumed, result;
    logic hold_exp;
    model(consumed, result);
    for (int i = 0; i < consumed; i++) send_byte(frame[i]);
    hold_exp = (result == R_ERR);
    chk({nm, "_done"},  {31'd0, Done},      {31'd0, result == R_DONE});
    chk({nm, "_error"}, {31'd0, Error},     {31'd0, result == R_ERR});
    chk({nm, "_hold"},  {31'd0, CpuHold},   {31'd0, hold_exp});
    chk({nm, "_ready"}, {31'd0, ByteReady}, 32'd0);
    repeat (2) @(negedge clk);
    chk({nm, "_writes_left"}, exp_q.size(), 32'd0);
    exp_q.delete();
    Clear = 1'b1;
    #1;
    chk({nm, "_ready_clear"}, {31'd0, ByteReady}, 32'd0);
    @(posedge clk);
    #1;
    Clear = 1'b0;
    #1;
    chk({nm, "_done_clr"},  {31'd0, Done},      32'd0);
    chk({nm, "_error_clr"}, {31'd0, Error},     32'd0);
    chk({nm, "_ready_clr"}, {31'd0, ByteReady}, 32'd1);
    chk({nm, "_hold_clr"},  {31'd0, CpuHold},   {31'd0, hold_exp});
    $display("frame %s: %0d bytes, result %0d", nm, consumed, result);
  endtask

  task automatic rand_frame(input int n_arg, input bit allow_bad);
    int n;
    frame.delete();
    repeat ($urandom_range(0, 2)) frame.push_back(8'($urandom_range(0, 8'hA4)));
    frame.push_back(HDR);
    frame.push_back(8'(n_arg));
    n = (n_arg == 0) ? 256 : n_arg;
    for (int k = 0; k < n; k++) begin
      repeat (3) frame.push_back(8'($urandom));
      if (allow_bad && ($urandom_range(0, 9) == 0))
        frame.push_back(8'($urandom_range(2, 255)));
      else
        frame.push_back(8'($urandom_range(0, 1)));
    end
    add_csum();
    if (allow_bad && ($urandom_range(0, 3) == 0))
      frame[frame.size()-1] = frame[frame.size()-1] + 8'($urandom_range(1, 255));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b1; ByteIn = 8'd0; ByteValid = 1'b0; Clear = 1'b0;
    #12;
    chk("rst_write", {31'd0, InstWrite}, 32'd0);
    chk("rst_addr",  {24'd0, InstAddress}, 32'd0);
    chk("rst_data",  {7'd0, InstData}, 32'd0);
    chk("rst_hold",  {31'd0, CpuHold}, 32'd0);
    chk("rst_done",  {31'd0, Done}, 32'd0);
    chk("rst_error", {31'd0, Error}, 32'd0);
    chk("rst_ready", {31'd0, ByteReady}, 32'd1);
    @(negedge clk);
    Reset = 1'b0;

    frame = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h56, 8'h01};
    add_csum();
    run_frame("single");

    frame = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h34, 8'h12, 8'h56, 8'h01};
    add_csum();
    run_frame("garbage");

    frame = '{8'hA5, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02};
    run_frame("bad_upper");

    frame = '{8'hA5, 8'h01, 8'h34, 8'h12, 8'h56, 8'h01, 8'h00};
    run_frame("bad_csum");

    frame = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h00, 8'h11, 8'h22,
              8'h33, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h00};
    add_csum();
    run_frame("wrap");

    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h34);
    send_byte(8'h12);
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_hold",  {31'd0, CpuHold}, 32'd0);
    chk("midrst_ready", {31'd0, ByteReady}, 32'd1);
    chk("midrst_write", {31'd0, InstWrite}, 32'd0);
    @(negedge clk);
    Reset = 1'b0;
    $display("frame midreset: 4 bytes then reset");

    frame = '{8'hA5, 8'h01, 8'h78, 8'h56, 8'h34, 8'h01};
    add_csum();
    run_frame("after_reset");

    for (int t = 0; t < 12; t++) begin
      rand_frame($urandom_range(1, 6), 1'b1);
      run_frame($sformatf("rand%0d", t));
    end

    rand_frame(0, 1'b0);
    run_frame("n256");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
